rob_param: RTL and testbench

Parametrised circular reorder buffer: allocates one entry per cycle at dispatch, marks entries complete from the common data bus (CDB), and retires one completed entry per cycle in program order from the head. Generalises the fixed 32-entry ROB with configurable depth and data width, tag return at dispatch, and precise branch-mispredict flush at retire. Sits between dispatch/rename and the architectural register file.

---
 rtl/rob_param_pkg.sv | 14 +
 rtl/rob_param_entry.sv | 61 ++++++
 rtl/rob_param.sv | 118 +++++++++++
 tb/tb_rob_param.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_param_pkg.sv
// Shared defaults and slot encodings for the parametrised reorder buffer.
// Every rob_param file imports this package.
package rob_param_pkg;

    localparam int TAG_BITS_DEF    = 5;
    localparam int ROB_ENTRIES_DEF = 2 ** TAG_BITS_DEF;
    localparam int DATA_WIDTH_DEF  = 64;
    localparam int REG_BITS_DEF    = 5;

    // Encoding of a slot's valid bit.
    localparam logic ROB_ENTRY_AVAILABLE = 1'b0;
    localparam logic ROB_ENTRY_OCCUPIED  = 1'b1;

endpackage : rob_param_pkg

// File: rtl/rob_param_entry.sv
// One reorder-buffer slot. It is written at dispatch and updated from the CDB.
// It is cleared when it retires or when the buffer is flushed.
module rob_param_entry
    import rob_param_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int REG_BITS   = REG_BITS_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_alloc,
    input  logic [REG_BITS-1:0]   i_alloc_reg,
    input  logic                  i_cdb_wr,
    input  logic [DATA_WIDTH-1:0] i_cdb_value,
    input  logic                  i_cdb_mispredict,
    input  logic                  i_clear,
    output logic                  o_valid,
    output logic                  o_complete,
    output logic                  o_mispredict,
    output logic [REG_BITS-1:0]   o_dest_reg,
    output logic [DATA_WIDTH-1:0] o_value
);

    logic                  r_valid;
    logic                  r_complete;
    logic                  r_mispredict;
    logic [REG_BITS-1:0]   r_dest_reg;
    logic [DATA_WIDTH-1:0] r_value;

    // Clear wins over allocate, and allocate wins over the CDB.
    // A CDB write only lands on an occupied slot.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_valid      <= ROB_ENTRY_AVAILABLE;
            r_complete   <= 1'b0;
            r_mispredict <= 1'b0;
            r_dest_reg   <= '0;
            r_value      <= '0;
        end else if (i_clear) begin
            r_valid      <= ROB_ENTRY_AVAILABLE;
            r_complete   <= 1'b0;
            r_mispredict <= 1'b0;
        end else if (i_alloc) begin
            r_valid      <= ROB_ENTRY_OCCUPIED;
            r_complete   <= 1'b0;
            r_mispredict <= 1'b0;
            r_dest_reg   <= i_alloc_reg;
        end else if (i_cdb_wr && (r_valid == ROB_ENTRY_OCCUPIED)) begin
            r_complete   <= 1'b1;
            r_mispredict <= i_cdb_mispredict;
            r_value      <= i_cdb_value;
        end
    end

    assign o_valid      = r_valid;
    assign o_complete   = r_complete;
    assign o_mispredict = r_mispredict;
    assign o_dest_reg   = r_dest_reg;
    assign o_value      = r_value;

endmodule : rob_param_entry

// File: rtl/rob_param.sv
// Circular reorder buffer. It allocates at the tail, completes entries from the CDB,
// and retires in order from the head. A mispredicted branch flushes the buffer when it retires.
module rob_param
    import rob_param_pkg::*;
#(
    parameter int ROB_ENTRIES = ROB_ENTRIES_DEF,
    parameter int TAG_BITS    = TAG_BITS_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int REG_BITS    = REG_BITS_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_dispatch_valid,
    input  logic [REG_BITS-1:0]   i_dispatch_dest_reg,
    output logic [TAG_BITS-1:0]   o_dispatch_tag,
    output logic                  o_rob_full,
    output logic                  o_rob_empty,
    output logic [TAG_BITS:0]     o_rob_count,
    input  logic                  i_cdb_valid,
    input  logic [TAG_BITS-1:0]   i_cdb_tag,
    input  logic [DATA_WIDTH-1:0] i_cdb_value,
    input  logic                  i_cdb_mispredict,
    output logic                  o_retire_valid,
    output logic [TAG_BITS-1:0]   o_retire_tag,
    output logic [REG_BITS-1:0]   o_retire_reg,
    output logic [DATA_WIDTH-1:0] o_retire_value,
    output logic                  o_flush
);

    localparam logic [TAG_BITS:0] FULL_COUNT = (TAG_BITS + 1)'(ROB_ENTRIES);

    logic [TAG_BITS-1:0] r_head;
    logic [TAG_BITS-1:0] r_tail;
    logic [TAG_BITS:0]   r_count;

    logic [ROB_ENTRIES-1:0] w_valid;
    logic [ROB_ENTRIES-1:0] w_complete;
    logic [ROB_ENTRIES-1:0] w_mispredict;
    logic [REG_BITS-1:0]    w_dest_reg [ROB_ENTRIES];
    logic [DATA_WIDTH-1:0]  w_value    [ROB_ENTRIES];

    logic w_full;
    logic w_empty;
    logic w_retire;
    logic w_flush;
    logic w_dispatch;

    // Full is taken from the registered count, so a retire in the same cycle never opens a slot.
    assign w_full     = (r_count == FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_retire   = w_valid[r_head] & w_complete[r_head];
    assign w_flush    = w_retire & w_mispredict[r_head];
    assign w_dispatch = i_dispatch_valid & ~w_full & ~w_flush;

    for (genvar g = 0; g < ROB_ENTRIES; g++) begin : g_entry
        logic w_alloc;
        logic w_cdb_wr;
        logic w_clear;

        assign w_alloc  = w_dispatch && (r_tail == TAG_BITS'(g));
        assign w_cdb_wr = i_cdb_valid && (i_cdb_tag == TAG_BITS'(g)) && !w_flush;
        assign w_clear  = w_flush || (w_retire && (r_head == TAG_BITS'(g)));

        rob_param_entry #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_BITS   (REG_BITS)
        ) u_entry (
            .i_clock          (i_clock),
            .i_reset          (i_reset),
            .i_alloc          (w_alloc),
            .i_alloc_reg      (i_dispatch_dest_reg),
            .i_cdb_wr         (w_cdb_wr),
            .i_cdb_value      (i_cdb_value),
            .i_cdb_mispredict (i_cdb_mispredict),
            .i_clear          (w_clear),
            .o_valid          (w_valid[g]),
            .o_complete       (w_complete[g]),
            .o_mispredict     (w_mispredict[g]),
            .o_dest_reg       (w_dest_reg[g]),
            .o_value          (w_value[g])
        );
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_dispatch) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_retire) begin
                r_head <= r_head + 1'b1;
            end
            unique case ({w_dispatch, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dispatch_tag = r_tail;
    assign o_rob_full     = w_full;
    assign o_rob_empty    = w_empty;
    assign o_rob_count    = r_count;
    assign o_retire_valid = w_retire;
    assign o_retire_tag   = r_head;
    assign o_retire_reg   = w_dest_reg[r_head];
    assign o_retire_value = w_value[r_head];
    assign o_flush        = w_flush;

endmodule : rob_param

// File: tb/tb_rob_param.sv
// Directed bench for rob_param.
// Expected retire packets {tag, reg, value} are queued when instructions are dispatched and compared in order as they retire.
module tb_rob_param;

  localparam int TB = 5;
  localparam int RB = 5;
  localparam int DW = 64;
  localparam int PW = TB + RB + DW;

  logic          clk;
  logic          rst;
  logic          dispatch_valid;
  logic [RB-1:0] dispatch_dest_reg;
  logic [TB-1:0] dispatch_tag;
  logic          rob_full;
  logic          rob_empty;
  logic [TB:0]   rob_count;
  logic          cdb_valid;
  logic [TB-1:0] cdb_tag;
  logic [DW-1:0] cdb_value;
  logic          cdb_mispredict;
  logic          retire_valid;
  logic [TB-1:0] retire_tag;
  logic [RB-1:0] retire_reg;
  logic [DW-1:0] retire_value;
  logic          flush;

  logic [PW-1:0] exp_q[$];
  logic [DW-1:0] vals [32];
  logic [TB-1:0] order [32];
  int n_checks  = 0;
  int n_fail    = 0;
  int n_retired = 0;

  rob_param dut (
    .i_clock             (clk),
    .i_reset             (rst),
    .i_dispatch_valid    (dispatch_valid),
    .i_dispatch_dest_reg (dispatch_dest_reg),
    .o_dispatch_tag      (dispatch_tag),
    .o_rob_full          (rob_full),
    .o_rob_empty         (rob_empty),
    .o_rob_count         (rob_count),
    .i_cdb_valid         (cdb_valid),
    .i_cdb_tag           (cdb_tag),
    .i_cdb_value         (cdb_value),
    .i_cdb_mispredict    (cdb_mispredict),
    .o_retire_valid      (retire_valid),
    .o_retire_tag        (retire_tag),
    .o_retire_reg        (retire_reg),
    .o_retire_value      (retire_value),
    .o_flush             (flush)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dispatch_valid    = 1'b0;
    dispatch_dest_reg = '0;
    cdb_valid         = 1'b0;
    cdb_tag           = '0;
    cdb_value         = '0;
    cdb_mispredict    = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic set_cdb(input logic [TB-1:0] t, input logic [DW-1:0] v, input logic mp);
    cdb_valid      = 1'b1;
    cdb_tag        = t;
    cdb_value      = v;
    cdb_mispredict = mp;
  endtask

  // scoreboard: every retire is compared against the oldest expected packet
  always @(negedge clk) begin
    if (!rst && retire_valid) begin
      n_retired++;
      if (exp_q.size() == 0) begin
        chk("unexpected_retire", 80'(retire_tag), 80'hFFFF);
      end else begin
        chk("retire_pkt", 80'({retire_tag, retire_reg, retire_value}), 80'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int guard;
    logic [TB-1:0] tmp;
    int j;
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      vals[i]  = {$urandom(), $urandom()};
      order[i] = TB'((i + 1) % 32);
    end
    #2;
    chk("reset_count", 80'(rob_count), 80'd0);
    chk("reset_empty", 80'(rob_empty), 80'd1);
    chk("reset_full", 80'(rob_full), 80'd0);
    chk("reset_retire", 80'({retire_valid, flush, retire_tag, retire_reg, retire_value}), 80'd0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("idle_tag", 80'(dispatch_tag), 80'd0);
    chk("idle_empty", 80'(rob_empty), 80'd1);
    chk("idle_retire", 80'(retire_valid), 80'd0);

    // three dispatches completed out of order, retired in order
    for (int i = 0; i < 3; i++) begin
      dispatch_valid    = 1'b1;
      dispatch_dest_reg = RB'(i + 1);
      exp_q.push_back({TB'(i), RB'(i + 1), DW'(8'h11 * i)});
      step();
    end
    dispatch_valid = 1'b0;
    chk("three_count", 80'(rob_count), 80'd3);
    chk("three_tag", 80'(dispatch_tag), 80'd3);
    set_cdb(5'd2, 64'h22, 1'b0);
    step();
    chk("no_early_retire", 80'(retire_valid), 80'd0);
    set_cdb(5'd0, 64'h00, 1'b0);
    step();
    chk("cdb_to_retire_1cyc", 80'(retire_valid), 80'd1);
    set_cdb(5'd1, 64'h11, 1'b0);
    step();
    idle_inputs();
    chk("retire_second", 80'({retire_valid, retire_tag}), 80'({1'b1, 5'd1}));
    step();
    chk("retire_third", 80'({retire_valid, retire_tag}), 80'({1'b1, 5'd2}));
    step();
    chk("drained_empty", 80'({rob_empty, rob_count}), 80'({1'b1, 6'd0}));

    // fill to capacity, overflow is dropped, then wrap the tail
    pulse_reset();
    for (int i = 0; i < 32; i++) begin
      dispatch_valid    = 1'b1;
      dispatch_dest_reg = RB'(i);
      exp_q.push_back({TB'(i), RB'(i), vals[i]});
      step();
    end
    chk("full_flag", 80'(rob_full), 80'd1);
    chk("full_count", 80'(rob_count), 80'd32);
    chk("full_tag", 80'(dispatch_tag), 80'd0);
    dispatch_dest_reg = 5'd7;
    step();
    chk("overflow_dropped", 80'({rob_count, dispatch_tag}), 80'({6'd32, 5'd0}));
    set_cdb(5'd0, vals[0], 1'b0);
    step();
    cdb_valid = 1'b0;
    dispatch_dest_reg = 5'd9;
    chk("full_retire_ready", 80'({retire_valid, rob_count}), 80'({1'b1, 6'd32}));
    step();
    chk("retire_blocks_dispatch", 80'({rob_count, dispatch_tag, rob_full}), 80'({6'd31, 5'd0, 1'b0}));
    exp_q.push_back({5'd0, 5'd9, 64'hA5A5_5A5A_0123_4567});
    step();
    dispatch_valid = 1'b0;
    chk("wrap_dispatch", 80'({rob_count, dispatch_tag}), 80'({6'd32, 5'd1}));
    vals[0] = 64'hA5A5_5A5A_0123_4567;
    for (int i = 31; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 32; i++) begin
      set_cdb(order[i], vals[order[i]], 1'b0);
      step();
    end
    idle_inputs();
    guard = 0;
    while (!rob_empty && guard < 100) begin
      step();
      guard++;
    end
    chk("fill_drain_empty", 80'(rob_empty), 80'd1);

    // mispredict flush from a non-zero head; concurrent dispatch and CDB are ignored
    for (int i = 0; i < 4; i++) begin
      dispatch_valid    = 1'b1;
      dispatch_dest_reg = RB'(5 + i);
      step();
    end
    dispatch_valid = 1'b0;
    exp_q.push_back({5'd1, 5'd5, 64'hBB});
    set_cdb(5'd1, 64'hBB, 1'b1);
    step();
    chk("flush_high", 80'({flush, retire_valid, retire_tag}), 80'({1'b1, 1'b1, 5'd1}));
    set_cdb(5'd3, 64'h33, 1'b0);
    dispatch_valid = 1'b1;
    step();
    idle_inputs();
    chk("post_flush", 80'({rob_empty, rob_count, dispatch_tag, flush}), 80'({1'b1, 6'd0, 5'd0, 1'b0}));
    set_cdb(5'd2, 64'h77, 1'b0);
    step();
    idle_inputs();
    chk("late_cdb_ignored", 80'({retire_valid, rob_empty}), 80'({1'b0, 1'b1}));
    for (int i = 0; i < 10; i++) begin
      dispatch_valid    = 1'b1;
      dispatch_dest_reg = RB'(i);
      step();
    end
    dispatch_valid = 1'b0;
    step();
    chk("stale_complete_cleared", 80'({retire_valid, rob_count}), 80'({1'b0, 6'd10}));

    // reset while the head is about to retire
    set_cdb(5'd0, 64'hCC, 1'b0);
    step();
    idle_inputs();
    chk("pre_reset_retire", 80'(retire_valid), 80'd1);
    rst = 1'b1;
    #1;
    chk("async_reset", 80'({rob_count, retire_valid, rob_empty}), 80'({6'd0, 1'b0, 1'b1}));
    step();
    rst = 1'b0;
    step();
    chk("after_reset", 80'({rob_count, dispatch_tag, retire_valid}), 80'd0);

    chk("queue_drained", 80'(exp_q.size()), 80'd0);
    chk("retire_total", 80'(n_retired), 80'd37);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rob_param
